// File: rtl/avg_pkg.sv
// ----------------------------------------------------------------------------
// avg_pkg
// Shared sizing helpers for the averaging datapath blocks.
//   id_width(n)      : bits needed to name one of n requesters (min 1)
//   cnt_width(depth) : bits for an occupancy count that can reach depth itself
// ----------------------------------------------------------------------------
package avg_pkg;

    localparam int unsigned AVG_DEF_NUM_REQ   = 4;
    localparam int unsigned AVG_DEF_TAG_DEPTH = 8;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/avg_tag_fifo.sv
// ----------------------------------------------------------------------------
// avg_tag_fifo
// Synchronous show-ahead FIFO holding the owner index of each in-flight
// averaging operation.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data (ignored when full)
//   push_data  : tag to store
//   pop        : drop the head entry (ignored when empty)
//   pop_data   : current head entry
//   count      : occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module avg_tag_fifo
    import avg_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            pop_data,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok  = push && (count_q != CW'(DEPTH));
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Pointers wrap naturally: DEPTH is a power of two.
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/avg_share_arb.sv
// ----------------------------------------------------------------------------
// avg_share_arb
// Round-robin arbiter sharing one pipelined averager among NUM_REQ requesters.
// Each issue records the winner in a tag FIFO; in-order results are routed
// back to the owner named by the FIFO head.
//   clk, rst       : clock, synchronous active-high reset
//   i_req          : per-requester request, held until its grant is seen
//   i_dat_vectors  : requester r's vector at [r*NUM_INPUTS*DWIDTH +: ...]
//   o_gnt          : one-hot one-cycle grant
//   o_dat_vector   : vector issued to the averager
//   o_dat_valid    : issue strobe to the averager
//   i_avg          : averager result
//   i_avg_valid    : averager result strobe (issue order, any latency)
//   o_avg          : routed result
//   o_avg_valid    : one-hot result strobe, bit = owner
//   o_avg_id       : owner index, valid with o_avg_valid
//   o_busy         : any operation in flight
//   o_err          : sticky, result arrived with nothing in flight
// ----------------------------------------------------------------------------
module avg_share_arb
    import avg_pkg::*;
#(
    parameter int unsigned NUM_REQ    = AVG_DEF_NUM_REQ,
    parameter int unsigned NUM_INPUTS = 16,
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned TAG_DEPTH  = AVG_DEF_TAG_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    i_req,
    input  logic [NUM_REQ*NUM_INPUTS*DWIDTH-1:0]  i_dat_vectors,
    output logic [NUM_REQ-1:0]                    o_gnt,
    output logic [NUM_INPUTS*DWIDTH-1:0]          o_dat_vector,
    output logic                                  o_dat_valid,
    input  logic [DWIDTH-1:0]                     i_avg,
    input  logic                                  i_avg_valid,
    output logic [DWIDTH-1:0]                     o_avg,
    output logic [NUM_REQ-1:0]                    o_avg_valid,
    output logic [id_width(NUM_REQ)-1:0]          o_avg_id,
    output logic                                  o_busy,
    output logic                                  o_err
);

    localparam int unsigned IDW = id_width(NUM_REQ);
    localparam int unsigned CW  = cnt_width(TAG_DEPTH);
    localparam int unsigned VW  = NUM_INPUTS * DWIDTH;

    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [VW-1:0]      dat_vector_q, dat_vector_d;
    logic               dat_valid_q, dat_valid_d;
    logic [DWIDTH-1:0]  avg_q, avg_d;
    logic [NUM_REQ-1:0] avg_valid_q, avg_valid_d;
    logic [IDW-1:0]     avg_id_q, avg_id_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [IDW-1:0]     last_q, last_d;

    logic [NUM_REQ-1:0] eligible;
    logic [IDW-1:0]     winner;
    logic               found;
    int unsigned        idx;
    logic               issue, pop, full;
    logic [IDW-1:0]     tag;
    logic [CW-1:0]      count, count_next;

    avg_tag_fifo #(
        .WIDTH (IDW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_data (winner),
        .pop       (pop),
        .pop_data  (tag),
        .count     (count)
    );

    // Round-robin search starting just after the last winner. A requester
    // whose grant is on the outputs right now is masked so it cannot be
    // granted twice before it has had a chance to drop its request.
    always_comb begin
        eligible = i_req & ~gnt_q;
        found    = 1'b0;
        winner   = last_q;
        idx      = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(last_q) + i) % NUM_REQ;
            if (!found && eligible[IDW'(idx)]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // Full blocks issue on the current count, even if a result pops now.
    assign full  = (count == CW'(TAG_DEPTH));
    assign issue = found && !full;
    assign pop   = i_avg_valid && (count != '0);

    always_comb begin
        gnt_d        = '0;
        dat_valid_d  = issue;
        dat_vector_d = dat_vector_q;
        last_d       = last_q;
        if (issue) begin
            gnt_d[winner] = 1'b1;
            dat_vector_d  = i_dat_vectors[VW * 32'(winner) +: VW];
            last_d        = winner;
        end

        avg_valid_d = '0;
        avg_d       = avg_q;
        avg_id_d    = avg_id_q;
        if (pop) begin
            avg_valid_d[tag] = 1'b1;
            avg_d            = i_avg;
            avg_id_d         = tag;
        end

        count_next = count + CW'(issue) - CW'(pop);
        busy_d     = (count_next != '0);
        err_d      = err_q | (i_avg_valid & (count == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q        <= '0;
            dat_vector_q <= '0;
            dat_valid_q  <= 1'b0;
            avg_q        <= '0;
            avg_valid_q  <= '0;
            avg_id_q     <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            last_q       <= IDW'(NUM_REQ - 1);
        end else begin
            gnt_q        <= gnt_d;
            dat_vector_q <= dat_vector_d;
            dat_valid_q  <= dat_valid_d;
            avg_q        <= avg_d;
            avg_valid_q  <= avg_valid_d;
            avg_id_q     <= avg_id_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            last_q       <= last_d;
        end
    end

    assign o_gnt        = gnt_q;
    assign o_dat_vector = dat_vector_q;
    assign o_dat_valid  = dat_valid_q;
    assign o_avg        = avg_q;
    assign o_avg_valid  = avg_valid_q;
    assign o_avg_id     = avg_id_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_avg_share_arb.sv
// ----------------------------------------------------------------------------
// tb_avg_share_arb
// Bench for avg_share_arb with a behavioural averager (fixed latency, can be
// stalled or released one result at a time) and grant/result scoreboards.
// ----------------------------------------------------------------------------
module tb_avg_share_arb;

    localparam int NR  = 4;
    localparam int NI  = 16;
    localparam int DW  = 8;
    localparam int TD  = 8;
    localparam int VW  = NI * DW;
    localparam int LAT = 5;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     i_req;
    logic [NR*VW-1:0]  i_dat_vectors;
    logic [NR-1:0]     o_gnt;
    logic [VW-1:0]     o_dat_vector;
    logic              o_dat_valid;
    logic [DW-1:0]     i_avg;
    logic              i_avg_valid;
    logic [DW-1:0]     o_avg;
    logic [NR-1:0]     o_avg_valid;
    logic [1:0]        o_avg_id;
    logic              o_busy;
    logic              o_err;

    avg_share_arb #(
        .NUM_REQ    (NR),
        .NUM_INPUTS (NI),
        .DWIDTH     (DW),
        .TAG_DEPTH  (TD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_dat_vectors (i_dat_vectors),
        .o_gnt         (o_gnt),
        .o_dat_vector  (o_dat_vector),
        .o_dat_valid   (o_dat_valid),
        .i_avg         (i_avg),
        .i_avg_valid   (i_avg_valid),
        .o_avg         (o_avg),
        .o_avg_valid   (o_avg_valid),
        .o_avg_id      (o_avg_id),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int tb_inflight = 0;
    int peak = 0;
    int budget = -1;          // results the averager may return; -1 = unlimited
    bit drop_on_gnt = 1'b0;
    bit inject_pop = 1'b0;

    int        exp_gnt_q[$];
    int        exp_res_id[$];
    logic [7:0] exp_res_avg[$];
    logic [7:0] pend_val[$];
    int        pend_due[$];

    function automatic logic [7:0] vec_avg(input logic [VW-1:0] v);
        int unsigned s;
        s = 0;
        for (int k = 0; k < NI; k++) s += v[k*DW +: DW];
        return 8'(s / NI);
    endfunction

    function automatic logic [VW-1:0] req_vec(input int r);
        logic [NR*VW-1:0] all;
        all = i_dat_vectors;
        return all[r*VW +: VW];
    endfunction

    // One clock: observe outputs #1 after the edge, score them, then drive
    // the averager input for the next edge.
    task automatic step();
        logic rst_edge, pop_edge;
        logic [NR-1:0] exp_oh;
        logic [VW-1:0] ev;
        int e;
        rst_edge = rst;
        pop_edge = i_avg_valid;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_edge) tb_inflight = 0;
        else tb_inflight = tb_inflight + (o_dat_valid === 1'b1 ? 1 : 0)
                                       - ((pop_edge && tb_inflight > 0) ? 1 : 0);
        if (tb_inflight > peak) peak = tb_inflight;

        n_vec++;
        if (o_busy !== (tb_inflight != 0)) begin
            n_err++;
            $display("FAIL busy cyc %0d: got %b exp %b", cyc, o_busy, tb_inflight != 0);
        end

        if (o_gnt !== '0) begin
            n_vec++;
            if (exp_gnt_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_grant cyc %0d: got %b exp 0000", cyc, o_gnt);
            end else begin
                e = exp_gnt_q.pop_front();
                exp_oh = '0;
                exp_oh[e] = 1'b1;
                ev = req_vec(e);
                if (o_gnt !== exp_oh || o_dat_valid !== 1'b1 || o_dat_vector !== ev) begin
                    n_err++;
                    $display("FAIL grant cyc %0d: got gnt %b valid %b vec %h exp gnt %b valid 1 vec %h",
                             cyc, o_gnt, o_dat_valid, o_dat_vector, exp_oh, ev);
                end
                exp_res_id.push_back(e);
                exp_res_avg.push_back(vec_avg(ev));
                if (drop_on_gnt) i_req[e] = 1'b0;
            end
        end else if (o_dat_valid !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL valid_no_grant cyc %0d: got valid %b exp 0", cyc, o_dat_valid);
        end

        if (o_dat_valid === 1'b1) begin
            pend_val.push_back(vec_avg(o_dat_vector));
            pend_due.push_back(cyc + LAT);
        end

        if (o_avg_valid !== '0) begin
            n_vec++;
            if (exp_res_id.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result cyc %0d: got valid %b exp 0000", cyc, o_avg_valid);
            end else begin
                e = exp_res_id.pop_front();
                exp_oh = '0;
                exp_oh[e] = 1'b1;
                ev[7:0] = exp_res_avg.pop_front();
                if (o_avg_valid !== exp_oh || o_avg_id !== 2'(e) || o_avg !== ev[7:0]) begin
                    n_err++;
                    $display("FAIL result cyc %0d: got valid %b id %0d avg %0d exp valid %b id %0d avg %0d",
                             cyc, o_avg_valid, o_avg_id, o_avg, exp_oh, e, ev[7:0]);
                end
            end
        end

        i_avg_valid = 1'b0;
        if (inject_pop) begin
            i_avg_valid = 1'b1;
            i_avg = 8'hAB;
            inject_pop = 1'b0;
        end else if (budget != 0 && pend_val.size() > 0 && pend_due[0] <= cyc) begin
            i_avg_valid = 1'b1;
            i_avg = pend_val.pop_front();
            void'(pend_due.pop_front());
            if (budget > 0) budget--;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = '0;
        i_avg_valid = 1'b0;
        inject_pop = 1'b0;
        budget = -1;
        exp_gnt_q.delete();
        exp_res_id.delete();
        exp_res_avg.delete();
        pend_val.delete();
        pend_due.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while ((exp_res_id.size() > 0 || pend_val.size() > 0 || tb_inflight > 0) && n < max_cycles) begin
            step();
            n++;
        end
        n_vec++;
        if (exp_res_id.size() != 0 || tb_inflight != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d outstanding exp 0", exp_res_id.size());
        end
    endtask

    task automatic check_idle(input string tag);
        n_vec++;
        if (o_gnt !== '0 || o_dat_valid !== 1'b0 || o_dat_vector !== '0 || o_avg !== '0 ||
            o_avg_valid !== '0 || o_avg_id !== '0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got gnt %b dv %b vec %h avg %h av %b id %0d busy %b err %b exp all 0",
                     tag, o_gnt, o_dat_valid, o_dat_vector, o_avg, o_avg_valid, o_avg_id, o_busy, o_err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_idle("reset_state");
        step();
        check_idle("idle_after_reset");
    endtask

    task automatic test_two_req();
        do_reset();
        drop_on_gnt = 1'b1;
        exp_gnt_q.push_back(0);
        exp_gnt_q.push_back(2);
        i_req = 4'b0101;
        step();
        n_vec++;
        if (o_gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL two_req_first: got %b exp 0001", o_gnt);
        end
        step();
        n_vec++;
        if (o_gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL two_req_second: got %b exp 0100", o_gnt);
        end
        step();
        n_vec++;
        if (o_gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL two_req_no_repeat: got %b exp 0000", o_gnt);
        end
        wait_drain(60);
    endtask

    task automatic test_round_robin_full();
        do_reset();
        drop_on_gnt = 1'b0;
        budget = 0;
        peak = 0;
        for (int k = 0; k < TD; k++) exp_gnt_q.push_back(k % NR);
        i_req = 4'b1111;
        for (int k = 0; k < TD; k++) begin
            step();
            n_vec++;
            if (o_dat_valid !== 1'b1) begin
                n_err++;
                $display("FAIL rr_issue_%0d: got valid %b exp 1", k, o_dat_valid);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (o_gnt !== '0 || tb_inflight != TD) begin
                n_err++;
                $display("FAIL full_block_%0d: got gnt %b inflight %0d exp 0000 and %0d", k, o_gnt, tb_inflight, TD);
            end
        end
        budget = 1;
        step();
        exp_gnt_q.push_back(0);
        step();
        n_vec++;
        if (o_gnt !== '0) begin
            n_err++;
            $display("FAIL full_pop_same_edge: got %b exp 0000", o_gnt);
        end
        step();
        i_req = '0;
        n_vec++;
        if (o_gnt !== 4'b0001 || tb_inflight != TD || peak != TD) begin
            n_err++;
            $display("FAIL full_resume: got gnt %b inflight %0d peak %0d exp 0001 %0d %0d",
                     o_gnt, tb_inflight, peak, TD, TD);
        end
        budget = -1;
        wait_drain(120);
    endtask

    task automatic test_result_routing();
        int g;
        int n;
        drop_on_gnt = 1'b1;
        for (int k = 0; k < NI; k++) begin
            i_dat_vectors[1*VW + k*DW +: DW] = 8'd10;
            i_dat_vectors[3*VW + k*DW +: DW] = 8'd200;
        end
        exp_gnt_q.push_back(1);
        exp_gnt_q.push_back(3);
        i_req = 4'b1010;
        step();
        g = cyc;
        n = 0;
        while (o_avg_valid === '0 && n < 30) begin
            step();
            n++;
        end
        n_vec++;
        if (o_avg !== 8'd10 || o_avg_valid !== 4'b0010 || o_avg_id !== 2'd1 || cyc != g + LAT + 1) begin
            n_err++;
            $display("FAIL route_r1: got avg %0d valid %b id %0d cyc %0d exp 10 0010 1 cyc %0d",
                     o_avg, o_avg_valid, o_avg_id, cyc, g + LAT + 1);
        end
        step();
        n_vec++;
        if (o_avg !== 8'd200 || o_avg_valid !== 4'b1000 || o_avg_id !== 2'd3) begin
            n_err++;
            $display("FAIL route_r3: got avg %0d valid %b id %0d exp 200 1000 3", o_avg, o_avg_valid, o_avg_id);
        end
        wait_drain(30);
    endtask

    task automatic test_empty_err();
        do_reset();
        inject_pop = 1'b1;
        step();
        step();
        n_vec++;
        if (o_err !== 1'b1 || o_avg_valid !== '0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL empty_pop: got err %b valid %b busy %b exp 1 0000 0", o_err, o_avg_valid, o_busy);
        end
        for (int k = 0; k < 3; k++) step();
        n_vec++;
        if (o_err !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: got %b exp 1", o_err);
        end
        do_reset();
        n_vec++;
        if (o_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_cleared: got %b exp 0", o_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drop_on_gnt = 1'b1;
        budget = 0;
        exp_gnt_q.push_back(0);
        exp_gnt_q.push_back(1);
        exp_gnt_q.push_back(2);
        i_req = 4'b0111;
        for (int k = 0; k < 4; k++) step();
        n_vec++;
        if (tb_inflight != 3 || o_busy !== 1'b1 || o_dat_vector === '0) begin
            n_err++;
            $display("FAIL mid_setup: got inflight %0d busy %b exp 3 1", tb_inflight, o_busy);
        end
        rst = 1'b1;
        step();
        check_idle("mid_reset");
        rst = 1'b0;
        exp_res_id.delete();
        exp_res_avg.delete();
        pend_val.delete();
        pend_due.delete();
        budget = -1;
        exp_gnt_q.push_back(0);
        exp_gnt_q.push_back(1);
        i_req = 4'b0011;
        step();
        n_vec++;
        if (o_gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL post_reset_first: got %b exp 0001", o_gnt);
        end
        step();
        n_vec++;
        if (o_gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL post_reset_second: got %b exp 0010", o_gnt);
        end
        wait_drain(60);
    endtask

    initial begin
        rst = 1'b1;
        i_req = '0;
        i_avg = '0;
        i_avg_valid = 1'b0;
        for (int k = 0; k < NR * VW / 32; k++) i_dat_vectors[k*32 +: 32] = $urandom;
        test_reset();
        test_two_req();
        test_round_robin_full();
        test_result_routing();
        test_empty_err();
        test_reset_mid();
        n_vec++;
        if (exp_gnt_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_grants: got %0d pending exp 0", exp_gnt_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
